// File: rtl/heartbeat_monitor_if.sv
// Heartbeat supervisor signal bundle: raw PWM heartbeat in, qualified health and
// period-measurement results out. The monitor uses the slave modport; whoever drives
// the heartbeat and consumes the results uses master.
interface heartbeat_monitor_if #(
  parameter int unsigned CNT_W = 24
) ();

  logic             pwm;
  logic             io;
  logic             dead;
  logic [1:0]       state;
  logic             rise;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             timeout;

  modport master (
    output pwm,
    input  io,
    input  dead,
    input  state,
    input  rise,
    input  period,
    input  period_vld,
    input  timeout
  );

  modport slave (
    input  pwm,
    output io,
    output dead,
    output state,
    output rise,
    output period,
    output period_vld,
    output timeout
  );

endinterface

// File: rtl/heartbeat_monitor.sv
// Per-CPU heartbeat supervisor.
// Synchronizes the asynchronous PWM heartbeat, optionally glitch-filters it, measures the
// rising-edge period and runs a hysteretic UNKNOWN/ALIVE/DEAD machine that drives io.
// Optional feature: define HB_GLITCH_FILTER_EN to compile in the FILT_LEN stability filter.
module heartbeat_monitor #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_PERIOD = 40000,
  parameter int unsigned MAX_PERIOD = 60000,
  parameter int unsigned GOOD_N     = 3,
  parameter int unsigned BAD_N      = 2,
  parameter int unsigned FILT_LEN   = 4
) (
  input logic                clk,
  input logic                rst_n,
  heartbeat_monitor_if.slave hb
);

  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StAlive   = 2'b01,
    StDead    = 2'b10
  } state_e;

  localparam int unsigned GoodW = $clog2(GOOD_N + 1);
  localparam int unsigned BadW  = $clog2(BAD_N + 1);

  localparam logic [CNT_W-1:0] CntSat = '1;
  localparam logic [CNT_W-1:0] CntMin = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CntTo  = CNT_W'(MAX_PERIOD);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(GOOD_N - 1);
  localparam logic [BadW-1:0]  BadLast  = BadW'(BAD_N - 1);

  // ---------------------------------------------------------------------------
  // Input path: 2-FF synchronizer, optional filter, registered edge detect
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic filt_q, filt_d;
  logic lvl_q, lvl_d;
  logic rise_q, rise_d;

  // Synchronizer next state.
  always_comb begin
    sync1_d = hb.pwm;
    sync2_d = sync1_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef HB_GLITCH_FILTER_EN
  localparam int unsigned StabW = $clog2(FILT_LEN + 1);

  // hist_q is the previous synchronized sample; stab_q is how many consecutive cycles
  // it has held its value, capped at FILT_LEN.
  logic             hist_q, hist_d;
  logic [StabW-1:0] stab_q, stab_d;

  // Stability filter: adopt the sampled level only once it has held for FILT_LEN cycles.
  always_comb begin
    hist_d = sync2_q;
    stab_d = stab_q;
    if (sync2_q != hist_q) begin
      stab_d = StabW'(1);
    end else if (stab_q < StabW'(FILT_LEN)) begin
      stab_d = stab_q + StabW'(1);
    end
    filt_d = (stab_q >= StabW'(FILT_LEN)) ? hist_q : filt_q;
  end

  // Filter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      stab_q <= '0;
    end else begin
      hist_q <= hist_d;
      stab_q <= stab_d;
    end
  end
`else
  logic unused_filt_len;
  assign unused_filt_len = FILT_LEN[0];

  // No filter: every synchronized transition is taken as-is.
  always_comb begin
    filt_d = sync2_q;
  end
`endif

  // Edge detect on the filtered level; rise is registered so it is glitch-free.
  always_comb begin
    lvl_d  = filt_q;
    rise_d = filt_q & ~lvl_q;
  end

  // Filtered level, delayed level and rise strobe flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Period measurement and event classification
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             have_ref_q, have_ref_d;
  logic             tmo;
  logic             vld;
  logic             in_range;
  logic             good_ev;
  logic             bad_ev;

  // Rise outranks the timeout condition; a timeout fires with or without a reference,
  // so a flat-lined input is caught straight out of reset.
  always_comb begin
    tmo      = ~rise_q & (cnt_q == CntTo);
    vld      = rise_q & have_ref_q;
    in_range = (cnt_q >= CntMin) && (cnt_q <= CntTo);
    good_ev  = vld & in_range;
    bad_ev   = (vld & ~in_range) | tmo;
  end

  // Counter, reference flag and held period next state.
  always_comb begin
    cnt_d      = cnt_q;
    have_ref_d = have_ref_q;
    period_d   = period_q;
    if (rise_q || tmo) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (tmo) begin
      have_ref_d = 1'b0;
    end else if (rise_q) begin
      have_ref_d = 1'b1;
    end
    if (vld) begin
      period_d = cnt_q;
    end
  end

  // Period measurement flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_W'(1);
      have_ref_q <= 1'b0;
      period_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      have_ref_q <= have_ref_d;
      period_q   <= period_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Hysteretic health state machine
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [BadW-1:0]  bad_cnt_q, bad_cnt_d;

  // Event counting and transitions. Reaching a threshold always lands in the matching
  // state and clears both counters, which also covers the stay-in-state case.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (good_ev) begin
      bad_cnt_d = '0;
      if (good_cnt_q >= GoodLast) begin
        state_d    = StAlive;
        good_cnt_d = '0;
      end else begin
        good_cnt_d = good_cnt_q + GoodW'(1);
      end
    end else if (bad_ev) begin
      good_cnt_d = '0;
      if (bad_cnt_q >= BadLast) begin
        state_d   = StDead;
        bad_cnt_d = '0;
      end else begin
        bad_cnt_d = bad_cnt_q + BadW'(1);
      end
    end
  end

  // State machine flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StUnknown;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  // Outputs come straight from flops or flop-only logic, so reset clears them at once.
  // period shows the fresh measurement in the same cycle as period_vld.
  always_comb begin
    hb.io         = (state_q == StAlive);
    hb.dead       = (state_q == StDead);
    hb.state      = state_q;
    hb.rise       = rise_q;
    hb.period     = vld ? cnt_q : period_q;
    hb.period_vld = vld;
    hb.timeout    = tmo;
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor: randomized PWM stimulus compared cycle by
// cycle with a run-length / event-level reference model, plus scenario checks.
module tb_heartbeat_monitor;

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned MIN_P    = 10;
  localparam int unsigned MAX_P    = 20;
  localparam int unsigned GOOD_N   = 3;
  localparam int unsigned BAD_N    = 2;
  localparam int unsigned FILT_LEN = 2;

`ifdef HB_GLITCH_FILTER_EN
  localparam bit FiltOn = 1'b1;
`else
  localparam bit FiltOn = 1'b0;
`endif
  // Samples a new level must hold before it counts, and edges from the sample that
  // completes that run to the rise strobe (3+FILT_LEN from the first sample overall).
  localparam int Need = FiltOn ? int'(FILT_LEN) : 1;
  localparam int Lat  = FiltOn ? 4 : 3;
  localparam int CntSat = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  heartbeat_monitor_if #(.CNT_W(CNT_W)) hb_if ();

  heartbeat_monitor #(
    .CNT_W      (CNT_W),
    .MIN_PERIOD (MIN_P),
    .MAX_PERIOD (MAX_P),
    .GOOD_N     (GOOD_N),
    .BAD_N      (BAD_N),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hb    (hb_if)
  );

  int n_checks = 0;
  int n_pass = 0;
  bit wave[$];

  // Reference model: health state 0 unknown, 1 alive, 2 dead.
  int m_cnt, m_ref, m_period, m_state, m_good, m_bad;
  int run_val, run_len, lvl;
  bit pipe[$];
  bit e_rise, e_vld, e_tmo, e_good, e_bad;

  task automatic model_reset();
    m_cnt = 1; m_ref = 0; m_period = 0; m_state = 0; m_good = 0; m_bad = 0;
    run_val = 0; run_len = Need; lvl = 0;
    pipe.delete();
    for (int k = 0; k < Lat; k++) pipe.push_back(1'b0);
    e_rise = 0; e_vld = 0; e_tmo = 0; e_good = 0; e_bad = 0;
  endtask

  // Advance the model by one clock edge at which pwm was sampled as s.
  task automatic model_edge(input bit s);
    bit hit;
    // Consequences of the events of the cycle that just ended.
    if (e_vld) m_period = m_cnt;
    if (e_rise || e_tmo) m_cnt = 1;
    else if (m_cnt < CntSat) m_cnt++;
    if (e_tmo) m_ref = 0;
    else if (e_rise) m_ref = 1;
    if (e_good) begin
      m_bad = 0; m_good++;
      if (m_good >= GOOD_N) begin m_state = 1; m_good = 0; end
    end
    if (e_bad) begin
      m_good = 0; m_bad++;
      if (m_bad >= BAD_N) begin m_state = 2; m_bad = 0; end
    end
    // Filtered level changes once a run of Need equal samples is seen.
    if (s == run_val) run_len++;
    else begin run_val = s; run_len = 1; end
    hit = 0;
    if (run_len >= Need && s != lvl) begin lvl = s; hit = s; end
    e_rise = pipe.pop_front();
    pipe.push_back(hit);
    // Events of the new cycle.
    e_vld  = e_rise && (m_ref != 0);
    e_tmo  = !e_rise && (m_cnt == MAX_P);
    e_good = e_vld && m_cnt >= MIN_P && m_cnt <= MAX_P;
    e_bad  = (e_vld && !(m_cnt >= MIN_P && m_cnt <= MAX_P)) || e_tmo;
  endtask

  function automatic logic [CNT_W+6:0] obs();
    return {hb_if.rise, hb_if.period_vld, hb_if.timeout, hb_if.state, hb_if.io, hb_if.dead,
            hb_if.period};
  endfunction

  function automatic logic [CNT_W+6:0] expv();
    logic [1:0] st;
    logic [CNT_W-1:0] per;
    st  = 2'(m_state);
    per = CNT_W'(e_vld ? m_cnt : m_period);
    return {e_rise, e_vld, e_tmo, st, m_state == 1, m_state == 2, per};
  endfunction

  task automatic step(input bit v);
    hb_if.pwm = v;
    @(posedge clk);
    #1;
    model_edge(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hb_if.pwm = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic add_seg(input int hi, input int lo);
    for (int k = 0; k < hi; k++) wave.push_back(1'b1);
    for (int k = 0; k < lo; k++) wave.push_back(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      hb_if.pwm = k[0];
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (obs() !== expv()) $display("FAIL reset_state: got %h want %h", obs(), expv());
    else n_pass++;
    hb_if.pwm = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_idle cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_square();
    int n_rise = 0, n_vld = 0, third = -1, io_at = -1;
    bit first_vld = 0, bad_per = 0;
    do_reset();
    wave.delete();
    for (int p = 0; p < 6; p++) add_seg(7, 8);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL square cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.rise) begin
        if (n_rise == 0) first_vld = hb_if.period_vld;
        n_rise++;
      end
      if (hb_if.period_vld) begin
        n_vld++;
        if (hb_if.period !== CNT_W'(15)) bad_per = 1;
        if (n_vld == 3) third = i;
      end
      if (hb_if.io && io_at < 0) io_at = i;
    end
    n_checks++;
    if (first_vld !== 1'b0) $display("FAIL square_arm: vld %0b want 0", first_vld); else n_pass++;
    n_checks++;
    if (n_rise != 6) $display("FAIL square_rises: got %0d want 6", n_rise); else n_pass++;
    n_checks++;
    if (n_vld != 5) $display("FAIL square_vlds: got %0d want 5", n_vld); else n_pass++;
    n_checks++;
    if (bad_per) $display("FAIL square_period: got a period other than 15"); else n_pass++;
    n_checks++;
    if (third < 0 || io_at != third + 1)
      $display("FAIL square_io_lat: io at %0d want %0d", io_at, third + 1);
    else n_pass++;
  endtask

  task automatic test_flatline();
    int tmo_at[$];
    int dead_at = -1;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      step(1'b0);
      n_checks++;
      if (obs() !== expv()) $display("FAIL flat0 cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.timeout) tmo_at.push_back(i);
      if (hb_if.dead && dead_at < 0) dead_at = i;
    end
    n_checks++;
    if (tmo_at.size() != 2 || tmo_at[0] != MAX_P - 2 || tmo_at[1] != 2 * MAX_P - 2)
      $display("FAIL flat0_timeouts: got %0d timeouts, want 2 at %0d,%0d", tmo_at.size(),
               MAX_P - 2, 2 * MAX_P - 2);
    else n_pass++;
    n_checks++;
    if (dead_at != 2 * MAX_P - 1) $display("FAIL flat0_dead: at %0d want %0d", dead_at,
                                           2 * MAX_P - 1);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      step(1'b1);
      n_checks++;
      if (obs() !== expv()) $display("FAIL flat1 cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
    end
    n_checks++;
    if (hb_if.dead !== 1'b1) $display("FAIL flat1_dead: got %b want 1", hb_if.dead);
    else n_pass++;
  endtask

  task automatic test_bad_period();
    int n_short = 0, n_drop = 0;
    bit was_alive = 0;
    do_reset();
    wave.delete();
    for (int p = 0; p < 5; p++) add_seg(7, 8);
    add_seg(2, 3);
    for (int p = 0; p < 3; p++) add_seg(7, 8);
    add_seg(2, 3);
    for (int p = 0; p < 3; p++) add_seg(7, 8);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL badper cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.period_vld && hb_if.period == CNT_W'(5)) n_short++;
      if (was_alive && hb_if.io !== 1'b1) n_drop++;
      if (hb_if.io) was_alive = 1;
    end
    n_checks++;
    if (n_short != 2) $display("FAIL badper_short: got %0d want 2", n_short); else n_pass++;
    n_checks++;
    if (n_drop != 0) $display("FAIL badper_stay_alive: %0d cycles not alive, want 0", n_drop);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int n_gl = 0, n_rise = 0, n_oor = 0;
    do_reset();
    wave.delete();
    for (int p = 0; p < 8; p++) begin
      int g;
      g = (p > 0) ? int'($urandom_range(12, 9)) : -1;
      if (g >= 0) n_gl++;
      for (int c = 0; c < 15; c++) wave.push_back(c < 7 || c == g);
    end
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL glitch cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.rise) n_rise++;
      if (hb_if.period_vld && (hb_if.period < CNT_W'(MIN_P) || hb_if.period > CNT_W'(MAX_P)))
        n_oor++;
    end
    n_checks++;
    if (n_rise != (FiltOn ? 8 : 8 + n_gl))
      $display("FAIL glitch_rises: got %0d want %0d", n_rise, FiltOn ? 8 : 8 + n_gl);
    else n_pass++;
    n_checks++;
    if ((n_oor > 0) != !FiltOn)
      $display("FAIL glitch_bad_event: got %0d bad periods, want %s", n_oor,
               FiltOn ? "none" : "some");
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    wave.delete();
    for (int p = 0; p < 14; p++)
      add_seg(int'($urandom_range(9, Need)), int'($urandom_range(16, Need)));
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_recover();
    int n_rise = 0, n_vld = 0;
    bit alive = 0;
    do_reset();
    for (int i = 0; i < 45; i++) step(1'b0);
    n_checks++;
    if (hb_if.dead !== 1'b1) $display("FAIL recover_dead: got %b want 1", hb_if.dead);
    else n_pass++;
    wave.delete();
    for (int p = 0; p < 6; p++) add_seg(7, 8);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL recover cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.io) alive = 1;
      if (!alive && hb_if.rise) n_rise++;
      if (!alive && hb_if.period_vld) n_vld++;
    end
    n_checks++;
    if (!alive || n_rise != 4 || n_vld != 3)
      $display("FAIL recover_alive: alive %0b after %0d rises/%0d goods, want 1 after 4/3",
               alive, n_rise, n_vld);
    else n_pass++;
  endtask

  task automatic test_midreset();
    int n_vld = 0, n_rise = 0;
    bit first_vld = 0;
    do_reset();
    wave.delete();
    for (int p = 0; p < 5; p++) add_seg(7, 8);
    add_seg(7, 0);
    for (int i = 0; i < wave.size(); i++) step(wave[i]);
    n_checks++;
    if (hb_if.io !== 1'b1) $display("FAIL midrst_pre_alive: io %b want 1", hb_if.io);
    else n_pass++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== expv()) $display("FAIL midrst_async: got %h want %h", obs(), expv());
    else n_pass++;
    hb_if.pwm = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    wave.delete();
    for (int p = 0; p < 3; p++) add_seg(7, 8);
    for (int i = 0; i < wave.size(); i++) begin
      step(wave[i]);
      n_checks++;
      if (obs() !== expv()) $display("FAIL midrst cyc %0d: got %h want %h", i, obs(), expv());
      else n_pass++;
      if (hb_if.rise) begin
        if (n_rise == 0) first_vld = hb_if.period_vld;
        n_rise++;
      end
      if (hb_if.period_vld) n_vld++;
    end
    n_checks++;
    if (first_vld !== 1'b0 || n_vld != 2)
      $display("FAIL midrst_arm: first vld %0b, %0d vlds, want 0 and 2", first_vld, n_vld);
    else n_pass++;
  endtask

  initial begin
    hb_if.pwm = 1'b0;
    test_reset();
    test_square();
    test_flatline();
    test_bad_period();
    test_glitch();
    test_random();
    test_recover();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
